// File: rtl/game_flow_if.sv
// game_flow_if: game-logic bundle; master drives frame_clk/keycode/hit/enemy_kill/layer_*, slave drives state flags/lives/score/level/enemy_alive/color_data
interface game_flow_if #(
  parameter int NUM_ENEMIES = 8,
  parameter int NUM_LAYERS = 4
);
  logic frame_clk;
  logic [7:0] keycode;
  logic hit;
  logic [NUM_ENEMIES-1:0] enemy_kill;
  logic [NUM_LAYERS-1:0] layer_valid;
  logic [24*NUM_LAYERS-1:0] layer_data;
  logic start;
  logic play;
  logic dying;
  logic gameover;
  logic [2:0] lives;
  logic [15:0] score;
  logic [3:0] level;
  logic [NUM_ENEMIES-1:0] enemy_alive;
  logic [23:0] color_data;
  modport master (
    output frame_clk, keycode, hit, enemy_kill, layer_valid, layer_data,
    input start, play, dying, gameover, lives, score, level, enemy_alive, color_data
  );
  modport slave (
    input frame_clk, keycode, hit, enemy_kill, layer_valid, layer_data,
    output start, play, dying, gameover, lives, score, level, enemy_alive, color_data
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: start/play/dying/gameover flow with lives, saturating score, waves and registered layer colour mux; ports clk, rst_n (async active-low), g (game_flow_if.slave)
module game_flow_ctrl #(
  parameter int NUM_ENEMIES = 8,
  parameter int NUM_LAYERS = 4,
  parameter int START_LIVES = 3,
  parameter int DEATH_FRAMES = 90,
  parameter logic [7:0] KEY_START = 8'h28
) (
  input logic clk,
  input logic rst_n,
  game_flow_if.slave g
);
  typedef enum logic [1:0] {S_START, S_PLAY, S_DYING, S_OVER} state_t;
  state_t state;
  logic fc_d;
  logic fc_dd;
  logic key_last;
  logic primed;
  logic tick;
  logic key_ev;
  logic [7:0] death_cnt;
  logic [NUM_ENEMIES-1:0] kill;
  logic [5:0] kill_cnt;
  logic [16:0] kill_sum;
  logic [16:0] bonus_sum;
  logic [NUM_LAYERS-1:0] vis;
  logic [23:0] mux_color;
  assign tick = fc_d & ~fc_dd;
  // primed stays low for the first cycle after reset so a key held through release is not a press
  assign key_ev = primed & (g.keycode == KEY_START) & ~key_last;
  assign kill = g.enemy_kill & g.enemy_alive;
  assign kill_sum = {1'b0, g.score} + 17'(kill_cnt) * 17'd10;
  assign bonus_sum = {1'b0, g.score} + 17'd100;
  assign vis = g.layer_valid & ~NUM_LAYERS'(state == S_DYING);
  assign g.start = state == S_START;
  assign g.play = state == S_PLAY;
  assign g.dying = state == S_DYING;
  assign g.gameover = state == S_OVER;
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) kill_cnt = kill_cnt + 6'(kill[i]);
  end
  always_comb begin
    mux_color = 24'h200000;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) mux_color = vis[i] ? g.layer_data[24*i +: 24] : mux_color;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_START;
      g.lives <= '0;
      g.score <= '0;
      g.level <= '0;
      g.enemy_alive <= '0;
      g.color_data <= '0;
      death_cnt <= '0;
      fc_d <= 1'b0;
      fc_dd <= 1'b0;
      key_last <= 1'b0;
      primed <= 1'b0;
    end else begin
      fc_d <= g.frame_clk;
      fc_dd <= fc_d;
      key_last <= g.keycode == KEY_START;
      primed <= 1'b1;
      g.color_data <= state == S_OVER ? 24'h505050 : mux_color;
      case (state)
        S_START:
          if (key_ev) begin
            state <= S_PLAY;
            g.lives <= 3'(START_LIVES);
            g.score <= '0;
            g.level <= '0;
            g.enemy_alive <= '1;
          end
        S_PLAY: begin
          if (g.enemy_alive == '0) begin
            g.enemy_alive <= '1;
            g.level <= g.level + 4'd1;
            g.score <= bonus_sum[16] ? 16'hFFFF : bonus_sum[15:0];
          end else begin
            g.enemy_alive <= g.enemy_alive & ~kill;
            g.score <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
          end
          if (g.hit) begin
            state <= S_DYING;
            g.lives <= g.lives - 3'(g.lives != 3'd0);
            death_cnt <= 8'(DEATH_FRAMES);
          end
        end
        S_DYING:
          if (tick) begin
            death_cnt <= death_cnt - 8'(death_cnt != 8'd0);
            if (death_cnt <= 8'd1) state <= g.lives != 3'd0 ? S_PLAY : S_OVER;
          end
        default:
          if (key_ev) state <= S_START;
      endcase
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed and random stimulus checked every cycle against a behavioural game model
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int m_mode;
  int m_lives;
  int m_score;
  int m_level;
  int m_left;
  int since_rst;
  logic [7:0] m_alive;
  logic [23:0] m_color;
  bit f1;
  bit f2;
  bit k_prev;
  game_flow_if #(.NUM_ENEMIES(8), .NUM_LAYERS(4)) gi ();
  game_flow_ctrl dut (.clk(clk), .rst_n(rst_n), .g(gi.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sat(input int v);
    return v > 65535 ? 65535 : v;
  endfunction
  task automatic model_reset();
    m_mode = 0;
    m_lives = 0;
    m_score = 0;
    m_level = 0;
    m_left = 0;
    m_alive = 8'h00;
    m_color = 24'h0;
    f1 = 0;
    f2 = 0;
    k_prev = 0;
    since_rst = 0;
  endtask
  task automatic model_step();
    bit tick;
    bit kev;
    bit found;
    tick = f1 && !f2;
    kev = since_rst > 0 && gi.keycode == 8'h28 && !k_prev;
    found = 0;
    m_color = 24'h200000;
    if (m_mode == 3) m_color = 24'h505050;
    else
      for (int i = 0; i < 4; i++)
        if (!found && gi.layer_valid[i] && !(i == 0 && m_mode == 2)) begin
          m_color = gi.layer_data[24*i +: 24];
          found = 1;
        end
    case (m_mode)
      0: if (kev) begin
        m_mode = 1;
        m_lives = 3;
        m_score = 0;
        m_level = 0;
        m_alive = 8'hFF;
      end
      1: begin
        if (m_alive == 8'h00) begin
          m_alive = 8'hFF;
          m_level = (m_level + 1) % 16;
          m_score = sat(m_score + 100);
        end else begin
          m_score = sat(m_score + 10 * $countones(gi.enemy_kill & m_alive));
          m_alive = m_alive & ~gi.enemy_kill;
        end
        if (gi.hit) begin
          m_lives = m_lives > 0 ? m_lives - 1 : 0;
          m_mode = 2;
          m_left = 90;
        end
      end
      2: if (tick) begin
        m_left--;
        if (m_left == 0) m_mode = m_lives > 0 ? 1 : 3;
      end
      default: if (kev) m_mode = 0;
    endcase
    f2 = f1;
    f1 = gi.frame_clk;
    k_prev = gi.keycode == 8'h28;
    since_rst++;
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask
  task automatic run_frames(input int n);
    repeat (n) begin
      gi.frame_clk = 1'b1;
      step();
      step();
      gi.frame_clk = 1'b0;
      step();
      step();
    end
  endtask
  always @(negedge clk) begin
    check("start", 32'(gi.start), 32'(m_mode == 0));
    check("play", 32'(gi.play), 32'(m_mode == 1));
    check("dying", 32'(gi.dying), 32'(m_mode == 2));
    check("gameover", 32'(gi.gameover), 32'(m_mode == 3));
    check("lives", 32'(gi.lives), 32'(m_lives));
    check("score", 32'(gi.score), 32'(m_score));
    check("level", 32'(gi.level), 32'(m_level));
    check("enemy_alive", 32'(gi.enemy_alive), 32'(m_alive));
    check("color_data", 32'(gi.color_data), 32'(m_color));
  end
  initial begin
    gi.frame_clk = 1'b0;
    gi.keycode = 8'h00;
    gi.hit = 1'b0;
    gi.enemy_kill = 8'h00;
    gi.layer_valid = 4'h0;
    gi.layer_data = '0;
    model_reset();
    repeat (3) step();
    check("rst_start", 32'(gi.start), 32'd1);
    check("rst_lives", 32'(gi.lives), 32'd0);
    check("rst_alive", 32'(gi.enemy_alive), 32'd0);
    check("rst_color", 32'(gi.color_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    gi.keycode = 8'h28;
    repeat (10) step();
    check("key_play", 32'(gi.play), 32'd1);
    check("key_lives", 32'(gi.lives), 32'd3);
    check("key_alive", 32'(gi.enemy_alive), 32'hFF);
    gi.keycode = 8'h00;
    gi.enemy_kill = 8'h05;
    step();
    check("kill1_score", 32'(gi.score), 32'd20);
    step();
    check("kill2_score", 32'(gi.score), 32'd20);
    check("kill2_alive", 32'(gi.enemy_alive), 32'hFA);
    gi.enemy_kill = 8'hFA;
    step();
    gi.enemy_kill = 8'h00;
    step();
    check("wave_alive", 32'(gi.enemy_alive), 32'hFF);
    check("wave_level", 32'(gi.level), 32'd1);
    check("wave_score", 32'(gi.score), 32'd180);
    gi.hit = 1'b1;
    gi.enemy_kill = 8'h01;
    step();
    gi.hit = 1'b0;
    gi.enemy_kill = 8'h00;
    check("hit_score", 32'(gi.score), 32'd190);
    check("hit_lives", 32'(gi.lives), 32'd2);
    check("hit_dying", 32'(gi.dying), 32'd1);
    run_frames(89);
    check("dying_89", 32'(gi.dying), 32'd1);
    run_frames(1);
    check("dying_90_play", 32'(gi.play), 32'd1);
    repeat (2) begin
      gi.hit = 1'b1;
      step();
      gi.hit = 1'b0;
      run_frames(90);
    end
    step();
    check("over_flag", 32'(gi.gameover), 32'd1);
    check("over_lives", 32'(gi.lives), 32'd0);
    gi.layer_valid = 4'hF;
    gi.layer_data = {$urandom, $urandom, $urandom};
    step();
    check("over_color", 32'(gi.color_data), 32'h505050);
    gi.keycode = 8'h28;
    step();
    gi.keycode = 8'h00;
    check("restart_start", 32'(gi.start), 32'd1);
    check("restart_score", 32'(gi.score), 32'd190);
    gi.layer_valid = 4'b0110;
    gi.layer_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    step();
    check("mux_layer1", 32'(gi.color_data), 32'h222222);
    gi.layer_valid = 4'b0000;
    step();
    check("mux_bg", 32'(gi.color_data), 32'h200000);
    for (int n = 0; n < 4000; n++) begin
      gi.frame_clk = 1'($urandom_range(0, 1));
      gi.keycode = $urandom_range(0, 15) == 0 ? 8'h28 : ($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00);
      gi.hit = $urandom_range(0, 49) == 0;
      gi.enemy_kill = $urandom_range(0, 2) == 0 ? 8'($urandom) & 8'($urandom) : 8'h00;
      gi.layer_valid = 4'($urandom);
      gi.layer_data = {$urandom, $urandom, $urandom};
      if (n >= 2000 && n < 2006) gi.keycode = 8'h28;
      if (n == 2000) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (n == 2003) rst_n = 1'b1;
      step();
      if (n == 2005) check("no_key_on_release", 32'(gi.start), 32'd1);
    end
    gi.hit = 1'b0;
    gi.keycode = 8'h00;
    gi.enemy_kill = 8'h00;
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    gi.keycode = 8'h28;
    step();
    gi.keycode = 8'h00;
    gi.enemy_kill = 8'hFF;
    repeat (800) step();
    check("score_saturated", 32'(gi.score), 32'hFFFF);
    gi.enemy_kill = 8'h00;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENEMIES, default 8, meaning enemy slots tracked (1..32).
REQ-002 SHALL have parameter NUM_LAYERS, default 4, meaning sprite layers in the colour mux (1..8); index 0 is highest priority.
REQ-003 SHALL have parameter START_LIVES, default 3, meaning lives loaded on game start (1..7).
REQ-004 SHALL have parameter DEATH_FRAMES, default 90, meaning frame ticks spent in DYING (1..255).
REQ-005 SHALL have parameter KEY_START, default 8'h28, meaning the keycode that starts or restarts the game.
REQ-006 Clk  in  1  system clock, 50 MHz; one clock; all state on its rising edge.
REQ-007 Reset  in  1  reset, asynchronous, active-low.
REQ-008 frame_clk  in  1  ~60 Hz frame strobe, synchronous to Clk, any duty cycle.
REQ-009 keycode  in  8  current key pressed; 8'h00 means none.
REQ-010 hit  in  1  user ship hit this cycle.
REQ-011 enemy_kill  in  NUM_ENEMIES  one-hot-or-more enemy-destroyed pulses.
REQ-012 layer_valid  in  NUM_LAYERS  pixel-on flag per layer for current DrawX/DrawY.
REQ-013 layer_data  in  24*NUM_LAYERS  {R,G,B} per layer; layer k at bits [24k+23:24k].
REQ-014 start, play, dying, gameover  out  1 each  one-hot state flags.
REQ-015 lives  out  3  remaining lives.
REQ-016 score  out  16  saturating score.
REQ-017 level  out  4  current wave, wraps 15->0.
REQ-018 enemy_alive  out  NUM_ENEMIES  alive mask.
REQ-019 color_data  out  24  registered {R,G,B} to the colour mapper.

Function
REQ-020 frame tick SHALL be the Clk cycle after frame_clk is seen rising (registered edge detect); one tick per rising edge.
REQ-021 key press SHALL be an edge event: keycode==KEY_START this cycle and !=KEY_START last cycle; a held key generates one event only.
REQ-022 FSM states SHALL be START, PLAY, DYING, GAMEOVER; exactly one flag high at all times.
REQ-023 START -> PLAY on key press: lives=START_LIVES, score=0, level=0, enemy_alive=all ones, same edge.
REQ-024 In PLAY, each set bit of enemy_kill AND enemy_alive SHALL clear that bit and add 10 per cleared bit (popcount) to score; kills of dead slots ignored.
REQ-025 score SHALL saturate at 16'hFFFF, never wrap.
REQ-026 In PLAY, when enemy_alive becomes zero, the next cycle SHALL refill enemy_alive to all ones, increment level, add 100 bonus (saturating).
REQ-027 In PLAY, hit SHALL decrement lives and go to DYING; death counter loaded with DEATH_FRAMES.
REQ-028 Same-cycle hit and enemy_kill: kills SHALL be scored first, then hit processed, same edge.
REQ-029 DYING SHALL ignore hit and enemy_kill; decrement counter per frame tick; at 0 go PLAY if lives>0 else GAMEOVER.
REQ-030 GAMEOVER -> START on key press; score and level held until START->PLAY.
REQ-031 hit outside PLAY SHALL have no effect; lives never underflow below 0.
REQ-032 Colour: START/PLAY/DYING SHALL output layer_data of lowest-index valid layer, else background 24'h200000; DYING forces layer 0 blank.
REQ-033 GAMEOVER SHALL output 24'h505050 regardless of layers.
REQ-034 color_data SHALL be registered: exactly 1 Clk latency from layer inputs.

Reset
REQ-035 On Reset low, asynchronously: state=START, lives=0, score=0, level=0, enemy_alive=0, death counter=0, color_data=0, edge-detect registers=0.
REQ-036 Reset asserted mid-game SHALL abort immediately to START; no key event generated on release even if KEY_START held.

Verification
REQ-037 Reset release, keycode 8'h28 held 10 cycles -> PLAY once, lives=3, enemy_alive=8'hFF; held key causes no further transitions.
REQ-038 PLAY, enemy_kill=8'b0000_0101 one cycle, then same again -> score=20 after first, unchanged after second.
REQ-039 Kill all 8 enemies -> next cycle enemy_alive=8'hFF, level=1, score=180.
REQ-040 hit with kill 8'h01 same cycle -> score+10, lives 3->2, DYING; 90 frame ticks later PLAY.
REQ-041 Three hits with DYING complete each time -> GAMEOVER, color_data=24'h505050; key press -> START, score retained.
REQ-042 layer_valid=4'b0110 with distinct data -> color_data equals layer 1 data one Clk later; layer_valid=0 -> 24'h200000.
